// File: rtl/ofdm_tx_formatter_pkg.sv
// rtl/ofdm_tx_formatter_pkg.sv - shared OFDM framing constants and types
package ofdm_tx_formatter_pkg;

  localparam int NFFT           = 1024;
  localparam int NCP            = 32;
  localparam int SYM_LEN        = NFFT + NCP;
  localparam int SYMS_PER_FRAME = 14;
  localparam int IN_W           = 20;
  localparam int OUT_W          = 16;
  localparam int P_W            = $clog2(SYM_LEN);
  localparam int SYM_W          = $clog2(SYMS_PER_FRAME);

  localparam logic [P_W-1:0]   P_LAST   = P_W'(SYM_LEN - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMS_PER_FRAME - 1);

  typedef struct packed {
    logic signed [IN_W-1:0] i;
    logic signed [IN_W-1:0] q;
  } iq_t;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/ofdm_tx_formatter_round_sat.sv
// rtl/ofdm_tx_formatter_round_sat.sv - combinational round-half-up and clamp to a narrower signed width
module iq_round_sat #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam int SH = IN_W - OUT_W;
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1 << (SH - 1));
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(1 << (OUT_W - 1)));

  logic signed [IN_W:0] xe;
  logic signed [IN_W:0] t;

  // One guard bit keeps the rounding add from wrapping at the positive rail.
  always_comb begin
    xe  = {x[IN_W-1], x};
    t   = (xe + HALF) >>> SH;
    sat = 1'b0;
    y   = t[OUT_W-1:0];
    if (t > MAXV) begin
      sat = 1'b1;
      y   = MAXV[OUT_W-1:0];
    end else if (t < MINV) begin
      sat = 1'b1;
      y   = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ofdm_tx_formatter.sv
// rtl/ofdm_tx_formatter.sv - symbol spacing check, frame tagging and DAC-width conversion after CP insertion
module ofdm_tx_formatter
  import ofdm_tx_formatter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_sop,
  input  logic signed [IN_W-1:0]  in_i,
  input  logic signed [IN_W-1:0]  in_q,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic [SYM_W-1:0]        sym_idx,
  output logic                    sync_err,
  output logic [15:0]             sat_cnt
);

  state_t             state, state_n;
  logic [P_W-1:0]     p, p_n;
  logic [SYM_W-1:0]   sym, sym_n;
  logic               accept, err;
  logic [P_W-1:0]     s_p;
  logic [SYM_W-1:0]   s_sym;
  iq_t                smp;
  logic signed [OUT_W-1:0] rnd_i, rnd_q;
  logic               sat_i, sat_q;

  assign smp = '{i: in_i, q: in_q};

  iq_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_round_i (.x(smp.i), .y(rnd_i), .sat(sat_i));
  iq_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_round_q (.x(smp.q), .y(rnd_q), .sat(sat_q));

  // s_p/s_sym describe the sample being accepted this cycle; p is the index expected next.
  always_comb begin
    state_n = state;
    p_n     = p;
    sym_n   = sym;
    accept  = 1'b0;
    err     = 1'b0;
    s_p     = '0;
    s_sym   = '0;
    case (state)
      IDLE: begin
        if (in_sop) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (in_sop) begin
          accept = 1'b1;
          if (p != '0)
            err = 1'b1;
          else if (sym != SYM_LAST)
            s_sym = sym + 1'b1;
        end else if (p == '0) begin
          err     = 1'b1;
          state_n = IDLE;
        end else begin
          accept = 1'b1;
          s_p    = p;
          s_sym  = sym;
        end
      end
      default: state_n = IDLE;
    endcase
    if (accept) begin
      p_n   = (s_p == P_LAST) ? '0 : s_p + 1'b1;
      sym_n = s_sym;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      sym       <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      sym_idx   <= '0;
      sync_err  <= 1'b0;
      sat_cnt   <= '0;
    end else if (en) begin
      state     <= state_n;
      p         <= p_n;
      sym       <= sym_n;
      out_valid <= accept;
      out_i     <= accept ? rnd_i : '0;
      out_q     <= accept ? rnd_q : '0;
      out_sop   <= accept && (s_p == '0);
      out_eop   <= accept && (s_p == P_LAST);
      out_sof   <= accept && (s_p == '0) && (s_sym == '0);
      out_eof   <= accept && (s_p == P_LAST) && (s_sym == SYM_LAST);
      sym_idx   <= accept ? s_sym : '0;
      sync_err  <= err;
      if (accept && (sat_i || sat_q) && (sat_cnt != 16'hFFFF))
        sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ofdm_tx_formatter.sv
// tb/tb_ofdm_tx_formatter.sv - randomized directed bench for ofdm_tx_formatter against a behavioural model
module tb_ofdm_tx_formatter;

  localparam int SYM_LEN = 1056;
  localparam int SPF     = 14;

  logic        clk = 1'b0;
  logic        rst, en, in_sop;
  logic [19:0] in_i, in_q;
  logic [15:0] out_i, out_q, sat_cnt;
  logic        out_valid, out_sop, out_eop, out_sof, out_eof, sync_err;
  logic [3:0]  sym_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_sof, cnt_eof, cnt_err;

  bit          m_run;
  int          m_pos, m_sym, m_sat;
  logic [57:0] e_vec;

  logic [15:0] exp_r [6];
  int          val_r [6];

  always #5 clk = ~clk;

  ofdm_tx_formatter dut (
    .clk(clk), .rst(rst), .en(en), .in_sop(in_sop), .in_i(in_i), .in_q(in_q),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_sof(out_sof), .out_eof(out_eof), .sym_idx(sym_idx),
    .sync_err(sync_err), .sat_cnt(sat_cnt)
  );

  function automatic logic [57:0] obs();
    return {out_valid, out_sop, out_eop, out_sof, out_eof, sym_idx, sync_err, out_i, out_q, sat_cnt};
  endfunction

  // Round half up to 16 bits via floor division by 16, then clamp.
  function automatic void round16(input int x, output int y, output bit s);
    int t;
    t = x + 8;
    t = (t >= 0) ? t / 16 : -((-t + 15) / 16);
    s = 1'b0;
    if (t > 32767) begin t = 32767; s = 1'b1; end
    else if (t < -32768) begin t = -32768; s = 1'b1; end
    y = t;
  endfunction

  function automatic int rval();
    if ($urandom_range(0, 31) == 0)
      return int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
    return int'($urandom_range(0, 1 << 15)) - (1 << 14);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_sym = 0; m_sat = 0; e_vec = '0;
  endtask

  task automatic model(input logic s, input int vi, input int vq);
    bit v = 1'b0;
    bit err = 1'b0;
    int pos = 0;
    int yi, yq;
    bit si, sq;
    if (!m_run) begin
      if (s) begin m_run = 1'b1; m_sym = 0; v = 1'b1; end
    end else if (s) begin
      err   = (m_pos != 0);
      m_sym = err ? 0 : (m_sym + 1) % SPF;
      v     = 1'b1;
    end else if (m_pos == 0) begin
      err   = 1'b1;
      m_run = 1'b0;
    end else begin
      v   = 1'b1;
      pos = m_pos;
    end
    if (v) m_pos = (pos + 1) % SYM_LEN;
    round16(vi, yi, si);
    round16(vq, yq, sq);
    if (v && (si || sq) && m_sat < 65535) m_sat++;
    e_vec = {v, v && pos == 0, v && pos == SYM_LEN - 1, v && pos == 0 && m_sym == 0,
             v && pos == SYM_LEN - 1 && m_sym == SPF - 1, v ? 4'(m_sym) : 4'd0, err,
             v ? 16'(yi) : 16'd0, v ? 16'(yq) : 16'd0, 16'(m_sat)};
  endtask

  task automatic check(input string tag, input logic [57:0] o, input logic [57:0] x);
    n_assert++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic drive(input logic s, input int vi, input int vq, input logic e);
    @(negedge clk);
    en = e; in_sop = s; in_i = vi[19:0]; in_q = vq[19:0];
    if (e) model(s, vi, vq);
    @(posedge clk);
    #1;
    check("stream", obs(), e_vec);
    if (e) begin
      cnt_sof += int'(out_sof);
      cnt_eof += int'(out_eof);
      cnt_err += int'(sync_err);
    end
  endtask

  task automatic sample(input logic s, input bit stall_ok);
    if (stall_ok && $urandom_range(0, 49) == 0) begin
      int n = int'($urandom_range(1, 10));
      for (int k = 0; k < n; k++)
        drive(1'($urandom_range(0, 1)), rval(), rval(), 1'b0);
    end
    drive(s, rval(), rval(), 1'b1);
  endtask

  task automatic symbol(input int n, input bit stall_ok);
    for (int k = 0; k < n; k++) sample(k == 0, stall_ok);
  endtask

  initial begin
    val_r = '{23, 24, -8, -9, 524287, -524288};
    exp_r = '{16'd1, 16'd2, 16'd0, 16'hFFFF, 16'h7FFF, 16'h8000};
    rst = 1'b1; en = 1'b0; in_sop = 1'b0; in_i = '0; in_q = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset", obs(), e_vec);
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 3; k++) drive(1'b0, rval(), rval(), 1'b1);

    cnt_sof = 0; cnt_eof = 0; cnt_err = 0;
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, val_r[k], rval(), 1'b1);
      n_assert++;
      assert (out_i === exp_r[k]) else begin
        n_fail++;
        $error("FAIL round observed=%h expected=%h", out_i, exp_r[k]);
      end
    end
    for (int k = 6; k < SYM_LEN; k++) sample(1'b0, 1'b0);
    for (int s = 1; s < 3 * SPF; s++) symbol(SYM_LEN, 1'b0);
    check("frame_sof", 58'(cnt_sof), 58'd3);
    check("frame_eof", 58'(cnt_eof), 58'd3);
    check("frame_err", 58'(cnt_err), 58'd0);

    symbol(SYM_LEN, 1'b1);
    for (int s = 1; s < 5; s++) symbol(SYM_LEN, 1'b1);
    symbol(500, 1'b0);
    drive(1'b1, rval(), rval(), 1'b1);
    check("early_sop", 58'({sync_err, out_sof, sym_idx, out_valid, out_eop}), 58'({1'b1, 1'b1, 4'd0, 1'b1, 1'b0}));
    for (int k = 1; k < SYM_LEN; k++) sample(1'b0, 1'b0);

    drive(1'b0, rval(), rval(), 1'b1);
    check("missing_sop", 58'({sync_err, out_valid}), 58'({1'b1, 1'b0}));
    drive(1'b0, rval(), rval(), 1'b1);
    drive(1'b0, rval(), rval(), 1'b1);
    for (int s = 0; s < 3; s++) symbol(SYM_LEN, 1'b0);
    symbol(700, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1 check("rst_async", obs(), e_vec);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) drive(1'b0, rval(), rval(), 1'b1);
    symbol(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
